// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor control path.
// Covers opcode encodings, T-state names and the packed control word.
package cpu_pkg;

    localparam int OPW = 4;
    localparam int STW = 3;

    localparam logic [OPW-1:0] OP_NOP = 4'b0000;
    localparam logic [OPW-1:0] OP_LDA = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB = 4'b0011;
    localparam logic [OPW-1:0] OP_STA = 4'b0100;
    localparam logic [OPW-1:0] OP_LDI = 4'b0101;
    localparam logic [OPW-1:0] OP_JMP = 4'b0110;
    localparam logic [OPW-1:0] OP_JC  = 4'b0111;
    localparam logic [OPW-1:0] OP_JZ  = 4'b1000;
    localparam logic [OPW-1:0] OP_OUT = 4'b1110;
    localparam logic [OPW-1:0] OP_HLT = 4'b1111;

    typedef enum logic [STW-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    // Field order follows the sequencer's output port list.
    typedef struct packed {
        logic pc_out;
        logic pc_en;
        logic pc_load;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
    } ctrl_t;

    function automatic logic has_execute(input logic [OPW-1:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: has_execute = 1'b1;
            default:                              has_execute = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-to-datapath bundle: run/decode inputs plus every strobe and status line.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic           en;
    logic [OPW-1:0] opcode;
    logic           carry;
    logic           zero;

    logic           pc_out;
    logic           pc_en;
    logic           pc_load;
    logic           mar_in;
    logic           ram_out;
    logic           ram_in;
    logic           ir_in;
    logic           ir_out;
    logic           a_in;
    logic           a_out;
    logic           b_in;
    logic           alu_out;
    logic           alu_sub;
    logic           flags_in;
    logic           out_in;
    logic           halt;
    logic [STW-1:0] tstate;
    logic           instr_done;

    modport master (
        input  en, opcode, carry, zero,
        output pc_out, pc_en, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
               halt, tstate, instr_done
    );

    modport slave (
        output en, opcode, carry, zero,
        input  pc_out, pc_en, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
               halt, tstate, instr_done
    );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and end-of-instruction marker.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [OPW-1:0] opcode_i,
    input  tstate_e        step_i,
    input  logic           carry_i,
    input  logic           zero_i,
    output ctrl_t          ctrl_o,
    output logic           last_step_o
);

    always_comb begin
        ctrl_o      = '0;
        last_step_o = 1'b0;
        case (step_i)
            T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
            end
            T1: begin
                ctrl_o.ram_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
                ctrl_o.pc_en   = 1'b1;
                last_step_o    = ~has_execute(opcode_i);
            end
            T2: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.mar_in = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.a_in   = 1'b1;
                        last_step_o   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_o.ir_out  = 1'b1;
                        ctrl_o.pc_load = 1'b1;
                        last_step_o    = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_o.ir_out  = carry_i;
                        ctrl_o.pc_load = carry_i;
                        last_step_o    = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl_o.ir_out  = zero_i;
                        ctrl_o.pc_load = zero_i;
                        last_step_o    = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_o.a_out  = 1'b1;
                        ctrl_o.out_in = 1'b1;
                        last_step_o   = 1'b1;
                    end
                    // HLT stays here with no strobes; the sequencer latches halt.
                    default: ;
                endcase
            end
            T3: begin
                case (opcode_i)
                    OP_LDA: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.a_in    = 1'b1;
                        last_step_o    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.b_in    = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_o.a_out  = 1'b1;
                        ctrl_o.ram_in = 1'b1;
                        last_step_o   = 1'b1;
                    end
                    default: last_step_o = 1'b1;
                endcase
            end
            T4: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_o.alu_out  = 1'b1;
                    ctrl_o.a_in     = 1'b1;
                    ctrl_o.flags_in = 1'b1;
                    ctrl_o.alu_sub  = (opcode_i == OP_SUB);
                end
                last_step_o = 1'b1;
            end
            // Unreachable encodings fall back to fetch.
            default: last_step_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: T-state counter, sticky halt latch and reset/halt gating
// around the microcode ROM.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    tstate_e step_q, step_d;
    logic    halt_q, halt_d;
    ctrl_t   rom_ctrl;
    ctrl_t   ctrl;
    logic    last_step;
    logic    run;
    logic    halt_step;

    microcode_rom u_rom (
        .opcode_i    (bus.opcode),
        .step_i      (step_q),
        .carry_i     (bus.carry),
        .zero_i      (bus.zero),
        .ctrl_o      (rom_ctrl),
        .last_step_o (last_step)
    );

    assign run       = bus.en & ~halt_q;
    assign halt_step = (step_q == T2) && (bus.opcode == OP_HLT);

    // HLT freezes the counter at T2 while the halt latch takes over.
    always_comb begin
        step_d = step_q;
        halt_d = halt_q;
        if (run) begin
            if (halt_step) begin
                halt_d = 1'b1;
            end else if (last_step) begin
                step_d = T0;
            end else begin
                step_d = tstate_e'(step_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
        end
    end

    // No bus driver or load strobe may fire during reset or once halted.
    assign ctrl = (clr || halt_q) ? '0 : rom_ctrl;

    assign bus.pc_out     = ctrl.pc_out;
    assign bus.pc_en      = ctrl.pc_en;
    assign bus.pc_load    = ctrl.pc_load;
    assign bus.mar_in     = ctrl.mar_in;
    assign bus.ram_out    = ctrl.ram_out;
    assign bus.ram_in     = ctrl.ram_in;
    assign bus.ir_in      = ctrl.ir_in;
    assign bus.ir_out     = ctrl.ir_out;
    assign bus.a_in       = ctrl.a_in;
    assign bus.a_out      = ctrl.a_out;
    assign bus.b_in       = ctrl.b_in;
    assign bus.alu_out    = ctrl.alu_out;
    assign bus.alu_sub    = ctrl.alu_sub;
    assign bus.flags_in   = ctrl.flags_in;
    assign bus.out_in     = ctrl.out_in;
    assign bus.halt       = halt_q;
    assign bus.tstate     = step_q;
    assign bus.instr_done = last_step & bus.en & ~halt_q & ~clr;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a table-driven microprogram model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int PC_OUT = 14, PC_EN = 13, PC_LOAD = 12, MAR_IN = 11, RAM_OUT = 10;
    localparam int RAM_IN = 9, IR_IN = 8, IR_OUT = 7, A_IN = 6, A_OUT = 5, B_IN = 4;
    localparam int ALU_OUT = 3, ALU_SUB = 2, FLAGS_IN = 1, OUT_IN = 0;

    typedef struct packed {
        logic [14:0] strobes;
        logic        halt;
        logic [2:0]  tstate;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic clr;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        expQ[$];
    string       tagQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [14:0] prog[16][5];
    int          progLen[16];
    int          mStep = 0;
    bit          mHalt = 1'b0;

    function automatic logic [14:0] sig(input int i);
        logic [14:0] one;
        one = 15'd1;
        return one << i;
    endfunction

    // Each opcode's microprogram written out as a table of strobe sets per step.
    task automatic buildProgram();
        for (int op = 0; op < 16; op++) begin
            for (int k = 0; k < 5; k++) prog[op][k] = '0;
            prog[op][0] = sig(PC_OUT) | sig(MAR_IN);
            prog[op][1] = sig(RAM_OUT) | sig(IR_IN) | sig(PC_EN);
            progLen[op] = 2;
        end
        prog[1][2] = sig(IR_OUT) | sig(MAR_IN);  prog[1][3] = sig(RAM_OUT) | sig(A_IN); progLen[1] = 4;
        prog[2][2] = sig(IR_OUT) | sig(MAR_IN);  prog[2][3] = sig(RAM_OUT) | sig(B_IN);
        prog[2][4] = sig(ALU_OUT) | sig(A_IN) | sig(FLAGS_IN);                             progLen[2] = 5;
        prog[3][2] = prog[2][2]; prog[3][3] = prog[2][3];
        prog[3][4] = prog[2][4] | sig(ALU_SUB);                                            progLen[3] = 5;
        prog[4][2] = sig(IR_OUT) | sig(MAR_IN);  prog[4][3] = sig(A_OUT) | sig(RAM_IN);  progLen[4] = 4;
        prog[5][2] = sig(IR_OUT) | sig(A_IN);                                              progLen[5] = 3;
        prog[6][2] = sig(IR_OUT) | sig(PC_LOAD);                                           progLen[6] = 3;
        prog[7][2] = sig(IR_OUT) | sig(PC_LOAD);                                           progLen[7] = 3;
        prog[8][2] = sig(IR_OUT) | sig(PC_LOAD);                                           progLen[8] = 3;
        prog[14][2] = sig(A_OUT) | sig(OUT_IN);                                            progLen[14] = 3;
        progLen[15] = 99;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic applyStimulus(input logic c, input logic e, input logic [3:0] op,
                                 input logic cy, input logic zr, input string tag);
        exp_t        x;
        logic [14:0] w;
        bit          last;
        @(posedge clk);
        #1;
        clr        = c;
        bus.en     = e;
        bus.opcode = op;
        bus.carry  = cy;
        bus.zero   = zr;

        w = prog[op][mStep];
        if (mStep == 2 && ((op == 4'd7 && !cy) || (op == 4'd8 && !zr))) w = '0;
        if (c || mHalt) w = '0;
        last      = (mStep == progLen[op] - 1);
        x.strobes = w;
        x.halt    = mHalt;
        x.tstate  = 3'(mStep);
        x.done    = last && e && !mHalt && !c;
        expQ.push_back(x);
        tagQ.push_back(tag);

        if (c) begin
            mStep = 0;
            mHalt = 1'b0;
        end else if (e && !mHalt) begin
            if (op == 4'd15 && mStep == 2) mHalt = 1'b1;
            else if (last)                 mStep = 0;
            else                           mStep = mStep + 1;
        end
    endtask

    task automatic checkOutput(input exp_t x, input string tag);
        logic [14:0] act;
        int          drivers;
        act = {bus.pc_out, bus.pc_en, bus.pc_load, bus.mar_in, bus.ram_out, bus.ram_in,
               bus.ir_in, bus.ir_out, bus.a_in, bus.a_out, bus.b_in, bus.alu_out,
               bus.alu_sub, bus.flags_in, bus.out_in};
        checks++;
        if (act !== x.strobes || bus.halt !== x.halt || bus.tstate !== x.tstate ||
            bus.instr_done !== x.done) begin
            errors++;
            $display("[TB] FAIL %s: got strobes=%b halt=%b tstate=%0d done=%b, want strobes=%b halt=%b tstate=%0d done=%b",
                     tag, act, bus.halt, bus.tstate, bus.instr_done,
                     x.strobes, x.halt, x.tstate, x.done);
        end
        drivers = $countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out});
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("[TB] FAIL %s bus_contention: got %0d drivers, want at most 1", tag, drivers);
        end
    endtask

    // Monitor: drains one expectation per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t  x;
            string t;
            x = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(x, t);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int haltCycles;
        logic [3:0] rop;
        buildProgram();
        clr        = 1'b1;
        bus.en     = 1'b1;
        bus.opcode = OP_LDA;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;

        repeat (2) applyStimulus(1, 1, OP_LDA, 0, 0, "reset");
        repeat (4) applyStimulus(0, 1, OP_LDA, 0, 0, "lda_after_reset");
        repeat (4) applyStimulus(0, 1, OP_NOP, 0, 0, "nop");
        repeat (5) applyStimulus(0, 1, OP_ADD, 0, 0, "add");
        repeat (5) applyStimulus(0, 1, OP_SUB, 0, 0, "sub");
        repeat (3) applyStimulus(0, 1, OP_JC, 0, 1, "jc_carry0");
        repeat (3) applyStimulus(0, 1, OP_JC, 1, 0, "jc_carry1");
        repeat (3) applyStimulus(0, 1, OP_JZ, 0, 1, "jz_zero1");
        repeat (3) applyStimulus(0, 1, OP_LDA, 0, 0, "lda_pause_lead");
        repeat (3) applyStimulus(0, 0, OP_LDA, 0, 0, "lda_paused_t3");
        applyStimulus(0, 1, OP_LDA, 0, 0, "lda_resume");
        repeat (3) applyStimulus(0, 1, OP_HLT, 0, 0, "hlt_run");
        repeat (3) applyStimulus(0, 1, OP_HLT, 1, 1, "hlt_frozen");
        applyStimulus(1, 1, OP_HLT, 0, 0, "hlt_clear");
        repeat (2) applyStimulus(0, 1, OP_NOP, 0, 0, "after_halt");
        repeat (3) applyStimulus(0, 1, OP_ADD, 0, 0, "abort_lead");
        applyStimulus(1, 1, OP_ADD, 0, 0, "abort_clr_t3");
        repeat (5) applyStimulus(0, 1, OP_ADD, 0, 0, "abort_restart");

        haltCycles = 0;
        rop        = OP_NOP;
        for (int i = 0; i < 800; i++) begin
            if (mStep == 0) rop = 4'($urandom_range(0, 15));
            haltCycles = mHalt ? haltCycles + 1 : 0;
            applyStimulus(($urandom_range(0, 39) == 0) || (haltCycles > 3),
                          ($urandom_range(0, 7) != 0), rop,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        repeat (2) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
